// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation encodings,
// FSM states and default latencies used by the unit, decoder and hazard logic.
package mult_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101
   } mdOp_e;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } mdState_e;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   // Multiplies and divides occupy the low half of the opcode space.
   function automatic logic isArithOp(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic isMultOp(input logic [2:0] op);
      return (op[2:1] == 2'b00);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage side of the multiply/divide unit: operands and opcode in,
// busy flag and HI/LO architectural registers out.
interface mult_div_unit_if;

   logic        En;
   logic [2:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output En, MDOp, A, B,
      input  Busy, HI, LO
   );

   modport slave (
      input  En, MDOp, A, B,
      output Busy, HI, LO
   );

endinterface

// File: rtl/mult_div_unit_arith.sv
// Combinational HI/LO result generator: signed/unsigned multiply and divide,
// including the divide-by-zero and most-negative/-1 corner cases.
module mult_div_unit_arith
   import mult_div_unit_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  mdOp_i,
   output logic [63:0] result_o
);

   logic        signedOp;
   logic [63:0] aExt;
   logic [63:0] bExt;
   logic [63:0] product;
   logic        negA;
   logic        negB;
   logic [31:0] absA;
   logic [31:0] absB;
   logic [31:0] quoMag;
   logic [31:0] remMag;
   logic [31:0] quo;
   logic [31:0] rem;

   assign signedOp = (mdOp_i == MD_MULT) || (mdOp_i == MD_DIV);

   assign aExt    = signedOp ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
   assign bExt    = signedOp ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
   assign product = aExt * bExt;

   // Divide on magnitudes, then restore signs: the quotient truncates toward
   // zero and the remainder follows the dividend. 0x80000000 / -1 falls out
   // naturally as quotient 0x80000000, remainder 0.
   assign negA   = signedOp & a_i[31];
   assign negB   = signedOp & b_i[31];
   assign absA   = negA ? (32'd0 - a_i) : a_i;
   assign absB   = negB ? (32'd0 - b_i) : b_i;
   assign quoMag = absA / absB;
   assign remMag = absA % absB;
   assign quo    = (negA ^ negB) ? (32'd0 - quoMag) : quoMag;
   assign rem    = negA ? (32'd0 - remMag) : remMag;

   always_comb begin
      result_o = 64'd0;
      case (mdOp_i)
         MD_MULT, MD_MULTU: result_o = product;
         MD_DIV, MD_DIVU:   result_o = (b_i == 32'd0) ? {a_i, 32'hFFFF_FFFF} : {rem, quo};
         default:           result_o = 64'd0;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: computes the result up front, holds it pending
// for the configured latency with Busy high, then commits it to HI/LO.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
   input  logic               CLK,
   input  logic               RESET,
   mult_div_unit_if.slave     md
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   mdState_e         state_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [31:0]      pendHi_q;
   logic [31:0]      pendLo_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic             busy_q;
   logic [63:0]      result;

   mult_div_unit_arith uArith (
      .a_i      (md.A),
      .b_i      (md.B),
      .mdOp_i   (md.MDOp),
      .result_o (result)
   );

   assign count_d = isMultOp(md.MDOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

   // Busy covers exactly the N cycles after the start edge; the commit to HI/LO
   // happens on the same edge that drops Busy. En while busy is ignored.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         pendHi_q <= '0;
         pendLo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (md.En) begin
                  if (isArithOp(md.MDOp)) begin
                     pendHi_q <= result[63:32];
                     pendLo_q <= result[31:0];
                     count_q  <= count_d;
                     busy_q   <= 1'b1;
                     state_q  <= ST_BUSY;
                  end else if (md.MDOp == MD_MTHI) begin
                     hi_q <= md.A;
                  end else if (md.MDOp == MD_MTLO) begin
                     lo_q <= md.A;
                  end
               end
            end
            ST_BUSY: begin
               if (count_q <= CNT_W'(1)) begin
                  hi_q    <= pendHi_q;
                  lo_q    <= pendLo_q;
                  count_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  count_q <= count_q - CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign md.Busy = busy_q;
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus random ops checked
// against an arithmetic reference model.
module tb_mult_div_unit;

   typedef struct {
      bit          arith;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      int          issueCycle;
      string       name;
   } exp_t;

   logic CLK;
   logic RESET;
   int   checks;
   int   errors;
   int   cycleCnt;
   int   busyLen;
   logic [31:0] modelHi;
   logic [31:0] modelLo;
   exp_t expQ[$];

   mult_div_unit_if md();

   mult_div_unit dut (
      .CLK   (CLK),
      .RESET (RESET),
      .md    (md.slave)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      cycleCnt = 0;
      forever begin
         @(posedge CLK);
         cycleCnt++;
      end
   end

   // Reference: plain 64-bit integer arithmetic straight from the ISA rules.
   function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      res = 64'd0;
      case (op)
         3'd0: begin p = sa * sb; res = p; end
         3'd1: begin p = ua * ub; res = p; end
         3'd2: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
         end
         3'd3: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin q = ua / ub; r = ua % ub; res = {r[31:0], q[31:0]}; end
         end
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actHi, input logic [31:0] actLo,
                              input int actLen, input logic [31:0] expHi, input logic [31:0] expLo,
                              input int expLen);
      checks++;
      if (actHi !== expHi || actLo !== expLo || actLen != expLen) begin
         errors++;
         $display("[TB] FAIL %s: got HI=%h LO=%h busy=%0d, expected HI=%h LO=%h busy=%0d",
                  name, actHi, actLo, actLen, expHi, expLo, expLen);
      end
   endtask

   // Monitor: a completed multiply/divide shows up as Busy falling; MT and
   // no-op entries are checked on the first negedge after their sampling edge.
   initial begin
      exp_t e;
      busyLen = 0;
      forever begin
         @(negedge CLK);
         if (md.Busy === 1'b1) begin
            busyLen++;
         end else if (busyLen > 0) begin
            if (expQ.size() == 0 || !expQ[0].arith) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_completion: got busy=%0d HI=%h LO=%h, expected no completion",
                        busyLen, md.HI, md.LO);
            end else begin
               e = expQ.pop_front();
               checkOutput(e.name, md.HI, md.LO, busyLen, e.hi, e.lo, e.cycles);
            end
            busyLen = 0;
         end else if (expQ.size() > 0 && !expQ[0].arith && cycleCnt > expQ[0].issueCycle) begin
            e = expQ.pop_front();
            checkOutput(e.name, md.HI, md.LO, int'(md.Busy), e.hi, e.lo, 0);
         end
      end
   end

   // Called at posedge+1; drives one op for a single cycle and queues its expectation.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input bit ignored, input string name);
      exp_t e;
      logic [63:0] r;
      md.En   = 1'b1;
      md.MDOp = op;
      md.A    = a;
      md.B    = b;
      if (!ignored) begin
         if (op <= 3'd3) begin
            r = refModel(op, a, b);
            modelHi  = r[63:32];
            modelLo  = r[31:0];
            e.arith  = 1'b1;
            e.cycles = (op <= 3'd1) ? 5 : 10;
         end else begin
            if (op == 3'd4) modelHi = a;
            if (op == 3'd5) modelLo = a;
            e.arith  = 1'b0;
            e.cycles = 0;
         end
         e.hi = modelHi;
         e.lo = modelLo;
         e.issueCycle = cycleCnt;
         e.name = name;
         expQ.push_back(e);
      end
      @(posedge CLK);
      #1;
      md.En   = 1'b0;
      md.MDOp = 3'd7;
      md.A    = $urandom;
      md.B    = $urandom;
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (expQ.size() > 0 && n < 60) begin
         @(posedge CLK);
         #1;
         n++;
      end
      if (expQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout_%s: got %0d pending results, expected 0", name, expQ.size());
         expQ.delete();
         busyLen = 0;
      end
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      checks  = 0;
      errors  = 0;
      modelHi = 32'd0;
      modelLo = 32'd0;
      RESET   = 1'b0;
      md.En   = 1'b0;
      md.MDOp = 3'd0;
      md.A    = 32'd0;
      md.B    = 32'd0;
      #2;
      checkOutput("reset_state", md.HI, md.LO, int'(md.Busy), 32'd0, 32'd0, 0);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;

      applyStimulus(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult_neg1x2");     waitDrain("mult");
      applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu_maxx2");     waitDrain("multu");
      applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");     waitDrain("div");
      applyStimulus(3'd3, 32'd7, 32'd0, 1'b0, "divu_by_zero");            waitDrain("divu0");
      applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf"); waitDrain("ovf");
      applyStimulus(3'd2, 32'h1234, 32'd0, 1'b0, "div_by_zero");          waitDrain("div0");
      applyStimulus(3'd4, 32'h1234_5678, 32'd0, 1'b0, "mthi");            waitDrain("mthi");
      applyStimulus(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, "mtlo");            waitDrain("mtlo");
      applyStimulus(3'd7, 32'hDEAD_BEEF, 32'd0, 1'b0, "noop_code7");      waitDrain("noop");

      applyStimulus(3'd2, 32'd100, 32'd7, 1'b0, "div_with_mtlo_ignored");
      applyStimulus(3'd5, 32'h5555_AAAA, 32'd0, 1'b1, "mtlo_while_busy");
      applyStimulus(3'd0, 32'd3, 32'd3, 1'b1, "mult_while_busy");
      waitDrain("busy_ignore");

      // Asynchronous reset in the third busy cycle of a divide.
      applyStimulus(3'd2, 32'd1000, 32'd3, 1'b0, "div_reset_victim");
      @(posedge CLK);
      @(posedge CLK);
      #2;
      RESET = 1'b0;
      #1;
      checkOutput("async_reset_mid_div", md.HI, md.LO, int'(md.Busy), 32'd0, 32'd0, 0);
      expQ.delete();
      busyLen = 0;
      modelHi = 32'd0;
      modelLo = 32'd0;
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      repeat (12) @(posedge CLK);
      #1;
      applyStimulus(3'd6, 32'd0, 32'd0, 1'b0, "pending_discarded");       waitDrain("discard");

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         applyStimulus(op, a, b, 1'b0, $sformatf("rand%0d_op%0d", i, op));
         waitDrain("rand");
      end

      repeat (2) @(posedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
